// File: rtl/ring_osc_freq_meter_if.sv
// Result channel of the ring-oscillator frequency meter: edge count, overflow flag and
// a valid/ready handshake. The meter drives the master side.
interface ring_osc_freq_meter_if #(
  parameter int unsigned COUNT_BITS = 16
) ();
  logic [COUNT_BITS-1:0] count;
  logic                  valid;
  logic                  ready;
  logic                  overflow;

  modport master (
    output count,
    output valid,
    output overflow,
    input  ready
  );

  modport slave (
    input  count,
    input  valid,
    input  overflow,
    output ready
  );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// Counts rising edges of an asynchronous divided ring-oscillator clock over a fixed gate
// window of system-clock cycles and presents the result on a valid/ready channel.
module ring_osc_freq_meter #(
  parameter int unsigned GATE_CYCLES = 1024,
  parameter int unsigned COUNT_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_osc_in,
  input  logic                  i_start,
  input  logic                  i_continuous,
  output logic                  o_busy,
  ring_osc_freq_meter_if.master m_if
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMeasure, StHold} state_e;

  state_e                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_hist;
  logic [GW-1:0]           r_gate_cnt;
  logic [COUNT_BITS-1:0]   r_edge_cnt;
  logic                    r_ovf;
  logic [COUNT_BITS-1:0]   r_count;
  logic                    r_overflow;
  logic                    r_valid;

  logic                    w_rise;
  logic                    w_edge_full;
  logic [COUNT_BITS-1:0]   w_edge_next;
  logic                    w_ovf_next;

  // osc_in is only ever sampled as data; the synchroniser runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_osc_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_rise      = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_edge_full = &r_edge_cnt;
  assign w_edge_next = (w_rise && !w_edge_full) ? r_edge_cnt + COUNT_BITS'(1) : r_edge_cnt;
  assign w_ovf_next  = r_ovf | (w_rise & w_edge_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state    <= StMeasure;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
          end
        end
        StMeasure: begin
          r_gate_cnt <= r_gate_cnt + GW'(1);
          r_edge_cnt <= w_edge_next;
          r_ovf      <= w_ovf_next;
          // The closing cycle's own rise is folded into the reported result.
          if (r_gate_cnt == GateLast) begin
            r_count    <= w_edge_next;
            r_overflow <= w_ovf_next;
            r_valid    <= 1'b1;
            r_state    <= StHold;
          end
        end
        StHold: begin
          if (r_valid && m_if.ready) begin
            r_valid <= 1'b0;
            if (i_continuous) begin
              r_state    <= StMeasure;
              r_gate_cnt <= '0;
              r_edge_cnt <= '0;
              r_ovf      <= 1'b0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m_if.count    = r_count;
  assign m_if.overflow = r_overflow;
  assign m_if.valid    = r_valid;
  assign o_busy        = (r_state != StIdle);

endmodule
